alu_cmd_driver: RTL
===================

Name: alu_cmd_driver

Overview:
Initiator-side sequencer for the registered ALU. It accepts operation requests on a valid/ready stream and drives the ALU command, X and Y inputs. It waits out the ALU's clocked latency, then captures the result and the Z/O/N flags and returns them on a response stream with backpressure. Optional result chaining feeds the previous result back as the next X operand. A saturating counter tallies overflow/divide-by-zero events.

Parameters:
numbits, 3, MSB index of an operand; operand width W = numbits+1, result width 2W
ALU_LAT, 1, clock edges from stable ALU inputs to valid ALU outputs (must be >= 1)
ERR_W, 8, width of the saturating error counter

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_cmd  in  3  ALU command code
req_x  in  W  X operand
req_y  in  W  Y operand
req_chain  in  1  1 = use low W bits of the last good result as X, ignoring req_x
alu_cmd  out  3  to ALU command_code
alu_x  out  W  to ALU xdata
alu_y  out  W  to ALU ydata
alu_result  in  2W  from ALU result
alu_flagZ  in  1  ALU zero flag
alu_flagO  in  1  ALU overflow / divide-by-zero flag
alu_flagN  in  1  ALU negative flag
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_result  out  2W  captured result
rsp_flags  out  3  {Z,O,N} captured flags
err_count  out  ERR_W  saturating count of responses with O=1
busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE; any in-flight operation is discarded with no response.
  - alu_cmd=000, alu_x=0, alu_y=0.
  - rsp_valid=0, rsp_result=0, rsp_flags=000.
  - err_count=0, last_result=0, cnt=0.
  - req_ready=1 once reset_n is high.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid=1, the request is accepted (edge E0):
    - alu_cmd <= req_cmd.
    - alu_y <= req_y.
    - alu_x <= req_chain ? last_result[W-1:0] : req_x.
    - cnt <= ALU_LAT; go to WAIT.
- WAIT:
  - req_ready=0.
  - On each edge: if cnt != 0, cnt <= cnt-1. If cnt == 0, capture and go to RESP.
  - Capture therefore occurs at edge E0+ALU_LAT+1, and rsp_valid rises then.
- Capture:
  - rsp_flags <= {alu_flagZ, alu_flagO, alu_flagN}.
  - If alu_flagO=0: rsp_result <= alu_result and last_result <= alu_result.
  - If alu_flagO=1: rsp_result <= 0 (the ALU result may be X) and last_result is unchanged; err_count increments, saturating at 2^ERR_W-1.
- RESP:
  - rsp_valid=1; rsp_result and rsp_flags are held stable until handshake.
  - On an edge with rsp_ready=1: rsp_valid <= 0, go to IDLE.
  - With rsp_ready held at 1, the response completes on the first rsp_valid cycle.
  - req_valid is ignored while not in IDLE; no request is accepted on the response handshake edge.
  - Minimum request-to-request spacing is ALU_LAT+3 cycles.
- alu_cmd/x/y hold their last values outside the accept edge; the ALU keeps recomputing them harmlessly.
- All 8 command codes are legal and are passed through unmodified.
- Chaining with no prior good result uses 0 as X.

Decomposition:
- Shared package alu_pkg holds:
  - Command constants: CMD_PASS=000, CMD_ADD=001, CMD_SUB=010, CMD_MUL=011, CMD_DIV=100, CMD_AND=101, CMD_OR=110, CMD_NOT=111.
  - Flag bit indices: FLG_Z=2, FLG_O=1, FLG_N=0.
  - Driver state encoding.
- One sub-module: sat_counter (parameter ERR_W; inputs inc, asynchronous active-low clear; saturating output).

Test Plan:
All scenarios use numbits=3, ALU_LAT=1, driver connected to the real ALU.
1. Reset check: assert reset_n=0 mid-clock -> all outputs 0 immediately; after release req_ready=1, busy=0.
2. ADD 5+6, accepted at E0 -> alu_cmd=001, alu_x=5, alu_y=6 after E0; rsp_valid=1 at E0+2, rsp_result=8'h0B, rsp_flags=000.
3. Chain: after scenario 2, MUL with req_chain=1, req_x=3, req_y=2 -> alu_x=4'hB (req_x ignored), rsp_result=8'h16.
4. DIV 7/0 -> rsp_result=0, rsp_flags O bit=1, err_count=1. A following chained ADD y=1 uses X=4'h6 (low bits of 8'h16) and returns 8'h07. Repeat DIV-by-0 300 times -> err_count stays at 255.
5. Backpressure: rsp_ready=0 for 5 cycles with req_valid=1 and new data -> rsp_valid, rsp_result and rsp_flags stable; req_ready=0; alu_* unchanged. Raise rsp_ready -> IDLE next edge, then the pending request is accepted.
6. Reset during WAIT (one edge after accept) -> state IDLE, rsp_valid never asserts, last_result=0; the next chained request drives alu_x=0.

Source files
------------

// File: rtl/alu_pkg.sv
//==========================================================================
// alu_pkg - command codes, flag indices and driver states (rev 1.0)
//==========================================================================
`default_nettype none

package alu_pkg;

   localparam logic [2:0] CMD_PASS = 3'b000;
   localparam logic [2:0] CMD_ADD  = 3'b001;
   localparam logic [2:0] CMD_SUB  = 3'b010;
   localparam logic [2:0] CMD_MUL  = 3'b011;
   localparam logic [2:0] CMD_DIV  = 3'b100;
   localparam logic [2:0] CMD_AND  = 3'b101;
   localparam logic [2:0] CMD_OR   = 3'b110;
   localparam logic [2:0] CMD_NOT  = 3'b111;

   localparam int FLG_Z = 2;
   localparam int FLG_O = 1;
   localparam int FLG_N = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } drv_state_t;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
//==========================================================================
// sat_counter - up counter that sticks at all-ones (rev 1.0)
//==========================================================================
`default_nettype none

module sat_counter #(
   parameter int ERR_W = 8
) (
   input  logic             clock,
   input  logic             clear_n,
   input  logic             inc,
   output logic [ERR_W-1:0] count
);

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         count <= '0;
      end else if (inc && (count != {ERR_W{1'b1}})) begin
         count <= count + ERR_W'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/alu_cmd_driver.sv
//==========================================================================
// alu_cmd_driver - request/response sequencer for the registered ALU (rev 1.0)
//==========================================================================
`default_nettype none

module alu_cmd_driver
   import alu_pkg::*;
#(
   parameter int numbits = 3,
   parameter int ALU_LAT = 1,
   parameter int ERR_W   = 8
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [2:0]             req_cmd,
   input  logic [numbits:0]       req_x,
   input  logic [numbits:0]       req_y,
   input  logic                   req_chain,
   output logic [2:0]             alu_cmd,
   output logic [numbits:0]       alu_x,
   output logic [numbits:0]       alu_y,
   input  logic [2*numbits+1:0]   alu_result,
   input  logic                   alu_flagZ,
   input  logic                   alu_flagO,
   input  logic                   alu_flagN,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [2*numbits+1:0]   rsp_result,
   output logic [2:0]             rsp_flags,
   output logic [ERR_W-1:0]       err_count,
   output logic                   busy
);

   localparam int W     = numbits + 1;
   localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT + 1) : 1;

   drv_state_t         state;
   drv_state_t         state_next;
   logic               accept;
   logic               capture;
   logic [CNT_W-1:0]   cnt;
   logic [2*W-1:0]     last_result;
   logic [2:0]         alu_flags;

   assign alu_flags = {alu_flagZ, alu_flagO, alu_flagN};

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      capture    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req_valid) begin
               accept     = 1'b1;
               state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt == '0) begin
               capture    = 1'b1;
               state_next = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Held low while reset is asserted so nothing is offered to an upstream
   // that is itself still coming out of reset.
   assign req_ready = reset_n && (state == ST_IDLE);
   assign rsp_valid = (state == ST_RESP);
   assign busy      = (state != ST_IDLE);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         alu_cmd     <= CMD_PASS;
         alu_x       <= '0;
         alu_y       <= '0;
         cnt         <= '0;
         rsp_result  <= '0;
         rsp_flags   <= '0;
         last_result <= '0;
      end else begin
         if (accept) begin
            alu_cmd <= req_cmd;
            alu_y   <= req_y;
            alu_x   <= req_chain ? last_result[W-1:0] : req_x;
            cnt     <= CNT_W'(ALU_LAT);
         end else if ((state == ST_WAIT) && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
         end
         if (capture) begin
            rsp_flags <= alu_flags;
            // An overflowing result may be undefined; never forward or chain it.
            if (alu_flags[FLG_O]) begin
               rsp_result <= '0;
            end else begin
               rsp_result  <= alu_result;
               last_result <= alu_result;
            end
         end
      end
   end

   sat_counter #(
      .ERR_W (ERR_W)
   ) u_err_counter (
      .clock   (clock),
      .clear_n (reset_n),
      .inc     (capture && alu_flagO),
      .count   (err_count)
   );

endmodule

`default_nettype wire
